// File: rtl/mario_anim_sched.sv
// Mario sprite animation sequencer and sprite ROM address scheduler.
// Once per video frame it advances the stand/walk/jump animation and the
// facing direction; every pixel clock it registers the sprite ROM address
// and a hit flag for the current raster position.
module mario_anim_sched #(
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int SCALE_LOG2  = 1,
  parameter int ANIM_DIV    = 6,
  parameter int JUMP_FRAMES = 30
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [9:0] sprite_x,
  input  logic [9:0] sprite_y,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump,
  input  logic       grounded,
  output logic [2:0] frame_sel,
  output logic       facing_left,
  output logic [7:0] rom_address,
  output logic       sprite_hit
);

  // Counter widths sized so the terminal value always fits.
  localparam int DIV_W  = (ANIM_DIV > 1)    ? $clog2(ANIM_DIV)    : 1;
  localparam int JCNT_W = (JUMP_FRAMES > 1) ? $clog2(JUMP_FRAMES) : 1;

  // On-screen footprint of the scaled sprite.
  localparam int BOX_W = SPR_W << SCALE_LOG2;
  localparam int BOX_H = SPR_H << SCALE_LOG2;

  // Frame codes presented to the frame-ROM mux.
  localparam logic [2:0] FRAME_STAND = 3'd0;
  localparam logic [2:0] FRAME_WALK1 = 3'd1;
  localparam logic [2:0] FRAME_WALK3 = 3'd3;
  localparam logic [2:0] FRAME_JUMP  = 3'd4;

  typedef enum logic [1:0] {
    ST_STAND = 2'd0,
    ST_WALK  = 2'd1,
    ST_JUMP  = 2'd2
  } animState_t;

  animState_t        state_q;
  logic [DIV_W-1:0]  divCnt_q;
  logic [JCNT_W-1:0] jumpCnt_q;
  logic [2:0]        frameSel_q;
  logic              facingLeft_q;
  logic [7:0]        romAddr_q;
  logic [7:0]        romAddr_d;
  logic              spriteHit_q;
  logic              spriteHit_d;

  logic              moving;
  logic              jumpStart;

  logic [10:0]       drawX11;
  logic [10:0]       drawY11;
  logic [10:0]       spriteX11;
  logic [10:0]       spriteY11;
  logic [10:0]       dx;
  logic [10:0]       dy;
  logic [10:0]       colIdx;
  logic [10:0]       rowIdx;
  logic [10:0]       colMir;
  logic              inBox;

  assign moving    = move_left ^ move_right;
  assign jumpStart = jump & grounded;

  // Animation FSM: all animation state and its registered outputs move only on frame ticks.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q      <= ST_STAND;
      divCnt_q     <= '0;
      jumpCnt_q    <= '0;
      frameSel_q   <= FRAME_STAND;
      facingLeft_q <= 1'b0;
    end else if (frame_tick) begin
      if (move_left && !move_right) begin
        facingLeft_q <= 1'b1;
      end else if (move_right && !move_left) begin
        facingLeft_q <= 1'b0;
      end

      case (state_q)
        ST_STAND: begin
          if (jumpStart) begin
            state_q    <= ST_JUMP;
            jumpCnt_q  <= '0;
            frameSel_q <= FRAME_JUMP;
          end else if (moving) begin
            state_q    <= ST_WALK;
            frameSel_q <= FRAME_WALK1;
            divCnt_q   <= '0;
          end
        end

        ST_WALK: begin
          if (jumpStart) begin
            state_q    <= ST_JUMP;
            jumpCnt_q  <= '0;
            frameSel_q <= FRAME_JUMP;
          end else if (!moving) begin
            state_q    <= ST_STAND;
            frameSel_q <= FRAME_STAND;
            divCnt_q   <= '0;
          end else if (divCnt_q == DIV_W'(ANIM_DIV - 1)) begin
            divCnt_q   <= '0;
            frameSel_q <= (frameSel_q == FRAME_WALK3) ? FRAME_WALK1 : frameSel_q + 3'd1;
          end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
          end
        end

        ST_JUMP: begin
          if (jumpCnt_q < JCNT_W'(JUMP_FRAMES - 1)) begin
            jumpCnt_q <= jumpCnt_q + JCNT_W'(1);
          end else if (grounded) begin
            divCnt_q <= '0;
            if (moving) begin
              state_q    <= ST_WALK;
              frameSel_q <= FRAME_WALK1;
            end else begin
              state_q    <= ST_STAND;
              frameSel_q <= FRAME_STAND;
            end
          end
        end

        default: begin
          state_q    <= ST_STAND;
          frameSel_q <= FRAME_STAND;
          divCnt_q   <= '0;
          jumpCnt_q  <= '0;
        end
      endcase
    end
  end

  // Raster hit test and texel address for the current pixel, in 11 bits so nothing wraps.
  always_comb begin
    drawX11   = {1'b0, DrawX};
    drawY11   = {1'b0, DrawY};
    spriteX11 = {1'b0, sprite_x};
    spriteY11 = {1'b0, sprite_y};
    dx        = drawX11 - spriteX11;
    dy        = drawY11 - spriteY11;
    colIdx    = dx >> SCALE_LOG2;
    rowIdx    = dy >> SCALE_LOG2;
    colMir    = facingLeft_q ? (11'(SPR_W - 1) - colIdx) : colIdx;
    inBox     = blank
              && (drawX11 >= spriteX11) && (drawX11 < spriteX11 + 11'(BOX_W))
              && (drawY11 >= spriteY11) && (drawY11 < spriteY11 + 11'(BOX_H));
    spriteHit_d = inBox;
    romAddr_d   = inBox ? 8'(rowIdx * 11'(SPR_W) + colMir) : 8'd0;
  end

  // Address pipeline stage: one posedge of latency so the ROM can sample on the following negedge.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      romAddr_q   <= '0;
      spriteHit_q <= 1'b0;
    end else begin
      romAddr_q   <= romAddr_d;
      spriteHit_q <= spriteHit_d;
    end
  end

  assign frame_sel   = frameSel_q;
  assign facing_left = facingLeft_q;
  assign rom_address = romAddr_q;
  assign sprite_hit  = spriteHit_q;

endmodule

// File: tb/tb_mario_anim_sched.sv
// Scoreboard testbench for mario_anim_sched: directed stimulus pushes
// hand-computed expectations, a monitor pops and compares them one cycle later.
module tb_mario_anim_sched;

   logic       vga_clk = 1'b0;
   logic       reset_n;
   logic       frame_tick;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic [9:0] sprite_x;
   logic [9:0] sprite_y;
   logic       move_left;
   logic       move_right;
   logic       jump;
   logic       grounded;
   logic [2:0] frame_sel;
   logic       facing_left;
   logic [7:0] rom_address;
   logic       sprite_hit;

   typedef struct packed {
      logic [2:0] fs;
      logic       fl;
      logic [7:0] addr;
      logic       hit;
      logic       chkAnim;
      logic       chkAddr;
   } exp_t;

   exp_t  expQ[$];
   string nameQ[$];
   logic  checkReq = 1'b0;
   logic  pendCheck = 1'b0;
   int    assertCount = 0;
   int    failCount = 0;

   mario_anim_sched #(
      .SPR_W(16), .SPR_H(16), .SCALE_LOG2(1), .ANIM_DIV(6), .JUMP_FRAMES(30)
   ) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
      .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .sprite_x(sprite_x), .sprite_y(sprite_y),
      .move_left(move_left), .move_right(move_right),
      .jump(jump), .grounded(grounded),
      .frame_sel(frame_sel), .facing_left(facing_left),
      .rom_address(rom_address), .sprite_hit(sprite_hit)
   );

   // 10 ns pixel clock.
   always #5 vga_clk = ~vga_clk;

   // Compare one popped expectation against the DUT outputs.
   task automatic checkOutput(input exp_t e, input string nm);
      if (e.chkAnim) begin
         assertCount++;
         if (frame_sel !== e.fs) begin
            failCount++;
            $display("[TB] FAIL %s frame_sel: got %0d expected %0d", nm, frame_sel, e.fs);
         end
         assertCount++;
         if (facing_left !== e.fl) begin
            failCount++;
            $display("[TB] FAIL %s facing_left: got %0b expected %0b", nm, facing_left, e.fl);
         end
      end
      if (e.chkAddr) begin
         assertCount++;
         if (rom_address !== e.addr) begin
            failCount++;
            $display("[TB] FAIL %s rom_address: got %0d expected %0d", nm, rom_address, e.addr);
         end
         assertCount++;
         if (sprite_hit !== e.hit) begin
            failCount++;
            $display("[TB] FAIL %s sprite_hit: got %0b expected %0b", nm, sprite_hit, e.hit);
         end
      end
   endtask

   // Remember whether an expectation was issued for the edge that just happened.
   always @(posedge vga_clk) pendCheck <= checkReq;

   // Monitor: on the negedge after a requested edge, pop the scoreboard and compare.
   always @(negedge vga_clk) begin
      if (pendCheck) begin
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
         end else begin
            checkOutput(expQ.pop_front(), nameQ.pop_front());
         end
      end
   end

   task automatic applyStimulus(input bit tick, input bit ml, input bit mr, input bit jp, input bit gd);
      frame_tick = tick;
      move_left  = ml;
      move_right = mr;
      jump       = jp;
      grounded   = gd;
   endtask

   task automatic pushExp(input logic [2:0] fs, input logic fl, input logic [7:0] addr,
                          input logic hit, input logic ca, input logic cd, input string nm);
      exp_t e;
      e.fs = fs; e.fl = fl; e.addr = addr; e.hit = hit; e.chkAnim = ca; e.chkAddr = cd;
      expQ.push_back(e);
      nameQ.push_back(nm);
      checkReq = 1'b1;
   endtask

   task automatic step();
      @(negedge vga_clk);
      frame_tick = 1'b0;
      checkReq   = 1'b0;
   endtask

   task automatic doTick(input bit ml, input bit mr, input bit jp, input bit gd,
                         input logic [2:0] fs, input logic fl, input string nm);
      applyStimulus(1'b1, ml, mr, jp, gd);
      pushExp(fs, fl, 8'd0, 1'b0, 1'b1, 1'b0, nm);
      step();
      step();
   endtask

   task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic blk,
                        input logic [7:0] addr, input logic hit, input string nm);
      DrawX = x;
      DrawY = y;
      blank = blk;
      pushExp(3'd0, 1'b0, addr, hit, 1'b0, 1'b1, nm);
      step();
   endtask

   // Directed stimulus sequence.
   initial begin
      reset_n  = 1'b0;
      DrawX    = 10'd100;
      DrawY    = 10'd200;
      blank    = 1'b1;
      sprite_x = 10'd100;
      sprite_y = 10'd200;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge vga_clk);

      // Reset held with movement, ticks and an in-box pixel: everything stays zero.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
         pushExp(3'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, $sformatf("reset c%0d", i));
         step();
      end
      reset_n = 1'b1;
      blank   = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      step();

      // Walk right: frame advances every 6 ticks, 1->2->3->1.
      for (int t = 1; t <= 20; t++) begin
         doTick(1'b0, 1'b1, 1'b0, 1'b1, 3'(1 + ((t - 1) / 6) % 3), 1'b0, $sformatf("walk t%0d", t));
      end
      doTick(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "walk release");

      // Address path, facing right, scale 2.
      pixel(10'd100, 10'd200, 1'b1, 8'd0,   1'b1, "addr topleft");
      pixel(10'd131, 10'd231, 1'b1, 8'd255, 1'b1, "addr botright");
      pixel(10'd132, 10'd231, 1'b1, 8'd0,   1'b0, "addr right edge");
      pixel(10'd99,  10'd200, 1'b1, 8'd0,   1'b0, "addr left edge");
      pixel(10'd102, 10'd204, 1'b1, 8'd33,  1'b1, "addr mid");
      pixel(10'd131, 10'd232, 1'b1, 8'd0,   1'b0, "addr bottom edge");
      pixel(10'd110, 10'd210, 1'b0, 8'd0,   1'b0, "addr blanked");
      sprite_x = 10'd630;
      pixel(10'd639, 10'd200, 1'b1, 8'd4,   1'b1, "clip inside");
      pixel(10'd0,   10'd200, 1'b1, 8'd0,   1'b0, "clip no wrap");
      sprite_x = 10'd100;
      blank    = 1'b0;

      // Jump from walk, grounded exit into walk at tick 30 with jump still held.
      doTick(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, "jmp walk in");
      doTick(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, "jmp enter");
      for (int k = 1; k < 30; k++) begin
         doTick(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, $sformatf("jmp k%0d", k));
      end
      doTick(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, "jmp exit walk");

      // Second jump: airborne past saturation, facing updates while jumping, lands to stand.
      doTick(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, "jmp2 enter");
      for (int k = 1; k <= 31; k++) begin
         doTick(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, $sformatf("jmp2 k%0d", k));
      end
      doTick(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, "jmp2 land stand");

      // Address path mirrored.
      pixel(10'd100, 10'd200, 1'b1, 8'd15,  1'b1, "mirror topleft");
      pixel(10'd131, 10'd231, 1'b1, 8'd240, 1'b1, "mirror botright");
      pixel(10'd102, 10'd204, 1'b1, 8'd46,  1'b1, "mirror mid");
      pixel(10'd102, 10'd204, 1'b0, 8'd0,   1'b0, "mirror blanked");
      blank = 1'b0;

      // Both directions held in walk stops the sprite and keeps facing.
      doTick(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, "walk left");
      doTick(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, "both held stand");

      // No frame tick for 1000 cycles while inputs churn: nothing moves.
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'b0, bit'(i % 2), bit'((i / 2) % 2 == 0), bit'((i / 4) % 2), 1'b1);
         if (i % 100 == 99) pushExp(3'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, $sformatf("no tick c%0d", i));
         step();
      end
      doTick(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, "tick after idle");

      // Reset in the middle of a jump returns to stand.
      doTick(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, "rst jump enter");
      reset_n = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      pushExp(3'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, "reset mid jump");
      step();
      reset_n = 1'b1;
      step();
      doTick(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "after reset stand");
      doTick(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, "rejump enter");
      doTick(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, "rejump k1");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 20 && expQ.size() != 0; i++) step();
      if (expQ.size() != 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL drain: got %0d entries left expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Runaway guard.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: got no end of stimulus expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/mario_anim_sched.md
Name: mario_anim_sched

Overview:
- Per-frame animation sequencer and ROM address scheduler for the Mario sprite datapath (sprite ROM + palette).
- Decides which sprite frame to show: stand, walk1/2/3 or jump. Decides facing direction.
- Once per video frame, advances animation state from player inputs.
- Every pixel clock, generates the registered sprite ROM address and an aligned hit flag for the current raster position.
- Sits between the game-logic inputs and the frame-ROM mux / palette / colour mapper.

Parameters:
- SPR_W, 16, sprite width in texels.
- SPR_H, 16, sprite height in texels.
- SCALE_LOG2, 1, on-screen magnification = 2**SCALE_LOG2 (power-of-two scaling only).
- ANIM_DIV, 6, video frames per walk step (must be >= 1).
- JUMP_FRAMES, 30, minimum video frames spent in JUMP.

Ports:
- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse once per video frame (start of vblank).
- DrawX  in  10  current raster column.
- DrawY  in  10  current raster row.
- blank  in  1  1 = active video.
- sprite_x  in  10  sprite top-left column.
- sprite_y  in  10  sprite top-left row.
- move_left  in  1  level, player holding left.
- move_right  in  1  level, player holding right.
- jump  in  1  level, jump requested.
- grounded  in  1  level, sprite on ground.
- frame_sel  out  3  0=stand, 1=walk1, 2=walk2, 3=walk3, 4=jump.
- facing_left  out  1  1 = mirror sprite horizontally.
- rom_address  out  8  address into selected sprite ROM (row*SPR_W+col).
- sprite_hit  out  1  current ROM data belongs to sprite pixel.

Behaviour:
- Reset (reset_n=0 at posedge): state=STAND, frame_sel=0, facing_left=0, div_cnt=0, jump_cnt=0, rom_address=0, sprite_hit=0. Reset wins over frame_tick. Reset mid-jump returns to STAND with jump_cnt=0.
- Animation state, frame_sel and facing_left change only on posedges where frame_tick=1, so there is no mid-frame tearing. Inputs are sampled on that same edge.
- moving = move_left XOR move_right. Both held or neither held = not moving.
- facing_left on tick:
  - left only -> 1.
  - right only -> 0.
  - otherwise hold.
  - This update applies in every state, including JUMP.
- STAND on tick:
  - jump & grounded -> JUMP; jump_cnt=0; frame_sel=4.
  - else moving -> WALK; frame_sel=1; div_cnt=0.
  - else stay.
- WALK on tick:
  - jump & grounded -> JUMP (jump has priority).
  - else !moving -> STAND; frame_sel=0; div_cnt=0.
  - else if div_cnt==ANIM_DIV-1: div_cnt=0; frame_sel steps 1->2->3->1 (wrap 3->1, never 0 or 4).
  - else div_cnt+1.
- JUMP on tick:
  - if jump_cnt<JUMP_FRAMES-1: jump_cnt+1.
  - else (saturated) and grounded: moving -> WALK with frame_sel=1, div_cnt=0; otherwise STAND.
  - else (saturated) and !grounded: stay, jump_cnt holds.
  - jump input is ignored while in JUMP.
- Address path: compute in 11-bit unsigned, no wrap.
  - W=SPR_W<<SCALE_LOG2, H=SPR_H<<SCALE_LOG2.
  - in_box = blank & DrawX>=sprite_x & DrawX<sprite_x+W & DrawY>=sprite_y & DrawY<sprite_y+H.
  - col=(DrawX-sprite_x)>>SCALE_LOG2; row=(DrawY-sprite_y)>>SCALE_LOG2.
  - If facing_left, col'=SPR_W-1-col.
- Latency:
  - Posedge N+1 registers rom_address = in_box ? row*SPR_W+col' : 0, and sprite_hit = in_box, from DrawX/DrawY/blank of cycle N.
  - The ROM samples on the negedge, so rom q and sprite_hit are both valid for sampling at posedge N+2.
- Sprite partly beyond 639/479 is clipped by the compare. It does not wrap to column 0.
- frame_sel, facing_left and the address path are independent. Address uses the current registered facing_left.

Test Plan:
- Reset held 3 cycles with move_right=1, frame_tick pulses -> frame_sel=0, facing_left=0, rom_address=0, sprite_hit=0 throughout.
- move_right=1, ANIM_DIV=6, 20 ticks -> frame_sel 1 on tick 1, 2 on tick 7, 3 on tick 13, 1 on tick 19. Release -> 0 on next tick.
- jump=1, grounded=1 while walking -> frame_sel=4 next tick. Grounded held 1 and jump released: JUMP exits on tick 30, to STAND or WALK per moving. With grounded=0 at tick 30 -> stays 4 until grounded=1.
- sprite_x=100, sprite_y=200, SCALE_LOG2=1, facing right:
  - DrawX=100, DrawY=200 -> rom_address=0, sprite_hit=1 one posedge later.
  - DrawX=131, DrawY=231 -> rom_address=255.
  - DrawX=132 -> sprite_hit=0.
- facing_left=1, DrawX=100, DrawY=200 -> rom_address=15. blank=0 inside box -> sprite_hit=0, rom_address=0.
- move_left and move_right both 1 in WALK -> STAND next tick, facing_left unchanged. frame_tick absent -> no state change for 1000 cycles.
